// File: rtl/csv_reader.sv
// csv_reader: streaming CSV tokenizer.
// Turns a byte stream into CHAR / FIELD_END / ROW_END tokens, tagged with a
// column index and a header-row flag, and flags column-count mismatches,
// column overflow and malformed quoting.
// Optional feature macro: CSV_READER_QUOTE_EN enables double-quote field
// quoting; without it '"' is an ordinary character and err_quote is tied 0.
module csv_reader #(
    parameter logic [7:0] DELIM    = 8'h2C,
    parameter int         MAX_COLS = 16,
    localparam int        COL_W    = $clog2(MAX_COLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_tok,
    output logic [7:0]       out_data,
    output logic [COL_W-1:0] out_col,
    output logic             out_header,
    output logic             err_cols,
    output logic             err_quote,
    output logic             err_ovf
);

    localparam logic [1:0] TOK_CHAR  = 2'd0;
    localparam logic [1:0] TOK_FIELD = 2'd1;
    localparam logic [1:0] TOK_ROW   = 2'd2;

    localparam logic [7:0] BYTE_LF    = 8'h0A;
    localparam logic [7:0] BYTE_CR    = 8'h0D;
    localparam logic [7:0] BYTE_QUOTE = 8'h22;

    localparam logic [COL_W-1:0] COL_MAX   = COL_W'(MAX_COLS - 1);
    localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
    localparam logic [COL_W:0]   COL_ONE_W = (COL_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_UNQ   = 2'd1
`ifdef CSV_READER_QUOTE_EN
        , ST_QUOTED = 2'd2,
        ST_QSEEN  = 2'd3
`endif
    } state_t;

    state_t           state_r;
    state_t           nstate_s;
    logic             emit_s;
    logic [1:0]       tok_s;
    logic [7:0]       data_s;
    logic             qerr_s;
    logic             accept_s;
    logic [COL_W:0]   col_cnt_s;

    logic             out_valid_r;
    logic [1:0]       out_tok_r;
    logic [7:0]       out_data_r;
    logic [COL_W-1:0] out_col_r;
    logic             out_header_r;
    logic [COL_W-1:0] col_r;
    logic [COL_W:0]   hdr_cnt_r;
    logic             hdr_seen_r;
    logic             err_cols_r;
    logic             err_ovf_r;

    assign in_ready   = !out_valid_r || out_ready;
    assign accept_s   = in_valid && in_ready;
    assign col_cnt_s  = {1'b0, col_r} + COL_ONE_W;

    assign out_valid  = out_valid_r;
    assign out_tok    = out_tok_r;
    assign out_data   = out_data_r;
    assign out_col    = out_col_r;
    assign out_header = out_header_r;
    assign err_cols   = err_cols_r;
    assign err_ovf    = err_ovf_r;

    // Decode the current byte against the parser state into token and next state.
    always_comb begin
        emit_s   = 1'b0;
        tok_s    = TOK_CHAR;
        data_s   = 8'h00;
        nstate_s = state_r;
        qerr_s   = 1'b0;
        case (state_r)
`ifdef CSV_READER_QUOTE_EN
            ST_QUOTED: begin
                if (in_data == BYTE_QUOTE) begin
                    nstate_s = ST_QSEEN;
                end else begin
                    emit_s = 1'b1;
                    data_s = in_data;
                end
            end
            ST_QSEEN: begin
                if (in_data == BYTE_QUOTE) begin
                    emit_s   = 1'b1;
                    data_s   = BYTE_QUOTE;
                    nstate_s = ST_QUOTED;
                end else if (in_data == DELIM) begin
                    emit_s   = 1'b1;
                    tok_s    = TOK_FIELD;
                    nstate_s = ST_START;
                end else if (in_data == BYTE_LF) begin
                    emit_s   = 1'b1;
                    tok_s    = TOK_ROW;
                    nstate_s = ST_START;
                end else if (in_data == BYTE_CR) begin
                    nstate_s = ST_QSEEN;
                end else begin
                    // Stray byte after a closing quote: keep it, flag the quoting.
                    qerr_s   = 1'b1;
                    emit_s   = 1'b1;
                    data_s   = in_data;
                    nstate_s = ST_UNQ;
                end
            end
`endif
            ST_START, ST_UNQ: begin
                if (in_data == DELIM) begin
                    emit_s   = 1'b1;
                    tok_s    = TOK_FIELD;
                    nstate_s = ST_START;
                end else if (in_data == BYTE_LF) begin
                    emit_s   = 1'b1;
                    tok_s    = TOK_ROW;
                    nstate_s = ST_START;
                end else if (in_data == BYTE_CR) begin
                    nstate_s = state_r;
`ifdef CSV_READER_QUOTE_EN
                end else if ((in_data == BYTE_QUOTE) && (state_r == ST_START)) begin
                    nstate_s = ST_QUOTED;
`endif
                end else begin
                    emit_s   = 1'b1;
                    data_s   = in_data;
                    nstate_s = ST_UNQ;
                end
            end
            default: begin
                nstate_s = ST_START;
            end
        endcase
    end

    // Parser state, output token register, column tracking and sticky errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_START;
            out_valid_r  <= 1'b0;
            out_tok_r    <= TOK_CHAR;
            out_data_r   <= 8'h00;
            out_col_r    <= '0;
            out_header_r <= 1'b1;
            col_r        <= '0;
            hdr_cnt_r    <= '0;
            hdr_seen_r   <= 1'b0;
            err_cols_r   <= 1'b0;
            err_ovf_r    <= 1'b0;
        end else begin
            if (out_ready) begin
                out_valid_r <= 1'b0;
            end
            // The header flag drops once the first row terminator leaves the block.
            if (out_valid_r && out_ready && (out_tok_r == TOK_ROW)) begin
                out_header_r <= 1'b0;
            end
            if (accept_s) begin
                state_r <= nstate_s;
                if (emit_s) begin
                    out_valid_r <= 1'b1;
                    out_tok_r   <= tok_s;
                    out_data_r  <= data_s;
                    out_col_r   <= col_r;
                    if (tok_s == TOK_FIELD) begin
                        if (col_r == COL_MAX) begin
                            err_ovf_r <= 1'b1;
                        end else begin
                            col_r <= col_r + COL_ONE;
                        end
                    end else if (tok_s == TOK_ROW) begin
                        col_r <= '0;
                        if (!hdr_seen_r) begin
                            hdr_cnt_r  <= col_cnt_s;
                            hdr_seen_r <= 1'b1;
                        end else if (col_cnt_s != hdr_cnt_r) begin
                            err_cols_r <= 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef CSV_READER_QUOTE_EN
    logic err_quote_r;

    // Sticky quoting error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_quote_r <= 1'b0;
        end else if (accept_s && qerr_s) begin
            err_quote_r <= 1'b1;
        end
    end

    assign err_quote = err_quote_r;
`else
    assign err_quote = 1'b0;
`endif

endmodule

// File: tb/tb_csv_reader.sv
// Directed testbench for csv_reader with a token scoreboard.
module tb_csv_reader;

    localparam logic [1:0] T_CHAR = 2'd0;
    localparam logic [1:0] T_FE   = 2'd1;
    localparam logic [1:0] T_RE   = 2'd2;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_tok;
    logic [7:0] out_data;
    logic [3:0] out_col;
    logic       out_header;
    logic       err_cols;
    logic       err_quote;
    logic       err_ovf;

    typedef struct packed {
        logic [1:0] tok;
        logic [7:0] data;
        logic [3:0] col;
        logic       hdr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors;
    int   miscompares;

    csv_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_tok    (out_tok),
        .out_data   (out_data),
        .out_col    (out_col),
        .out_header (out_header),
        .err_cols   (err_cols),
        .err_quote  (err_quote),
        .err_ovf    (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [1:0] tok, input logic [7:0] data,
                        input logic [3:0] col, input logic hdr);
        exp_t e;
        e.tok  = tok;
        e.data = (tok == T_CHAR) ? data : 8'h00;
        e.col  = col;
        e.hdr  = hdr;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain", exp_q.size(), 32'd0);
    endtask

    // Scoreboard: compare every token consumed downstream with the queue head.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_token", {30'd0, out_tok}, 32'hFFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("tok",    {30'd0, out_tok},    {30'd0, mon_e.tok});
                chk("data",   {24'd0, out_data},   {24'd0, mon_e.data});
                chk("col",    {28'd0, out_col},    {28'd0, mon_e.col});
                chk("header", {31'd0, out_header}, {31'd0, mon_e.hdr});
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        out_ready   = 1'b1;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
        chk("rst_out_tok",    {30'd0, out_tok},    32'd0);
        chk("rst_out_data",   {24'd0, out_data},   32'd0);
        chk("rst_out_col",    {28'd0, out_col},    32'd0);
        chk("rst_out_header", {31'd0, out_header}, 32'd1);
        chk("rst_err_cols",   {31'd0, err_cols},   32'd0);
        chk("rst_err_quote",  {31'd0, err_quote},  32'd0);
        chk("rst_err_ovf",    {31'd0, err_ovf},    32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Header row "a,b\n"
        push(T_CHAR, "a", 4'd0, 1'b1);
        push(T_FE,   0,   4'd0, 1'b1);
        push(T_CHAR, "b", 4'd1, 1'b1);
        push(T_RE,   0,   4'd1, 1'b1);
        send_str("a,b\n");
        drain();
        chk("header_dropped", {31'd0, out_header}, 32'd0);

        // Matching row with CR before LF
        push(T_CHAR, "c", 4'd0, 1'b0);
        push(T_FE,   0,   4'd0, 1'b0);
        push(T_CHAR, "d", 4'd1, 1'b0);
        push(T_RE,   0,   4'd1, 1'b0);
        send_str("c,d\r\n");
        drain();
        chk("err_cols_match", {31'd0, err_cols}, 32'd0);

        // Three-column row against a two-column header
        push(T_CHAR, "1", 4'd0, 1'b0);
        push(T_FE,   0,   4'd0, 1'b0);
        push(T_CHAR, "2", 4'd1, 1'b0);
        push(T_FE,   0,   4'd1, 1'b0);
        push(T_CHAR, "3", 4'd2, 1'b0);
        push(T_RE,   0,   4'd2, 1'b0);
        send_str("1,2,3\n");
        drain();
        chk("err_cols_set", {31'd0, err_cols}, 32'd1);

        // Quote handling: "ab"c
`ifdef CSV_READER_QUOTE_EN
        push(T_CHAR, "a", 4'd0, 1'b0);
        push(T_CHAR, "b", 4'd0, 1'b0);
        push(T_CHAR, "c", 4'd0, 1'b0);
        push(T_RE,   0,   4'd0, 1'b0);
        send_str("\"ab\"c\n");
        drain();
        chk("err_quote", {31'd0, err_quote}, 32'd1);
        push(T_CHAR, "p",   4'd0, 1'b0);
        push(T_CHAR, ",",   4'd0, 1'b0);
        push(T_CHAR, "q",   4'd0, 1'b0);
        push(T_CHAR, 8'h22, 4'd0, 1'b0);
        push(T_CHAR, "r",   4'd0, 1'b0);
        push(T_RE,   0,     4'd0, 1'b0);
        send_str("\"p,q\"\"r\"\n");
        drain();
`else
        push(T_CHAR, 8'h22, 4'd0, 1'b0);
        push(T_CHAR, "a",   4'd0, 1'b0);
        push(T_CHAR, "b",   4'd0, 1'b0);
        push(T_CHAR, 8'h22, 4'd0, 1'b0);
        push(T_CHAR, "c",   4'd0, 1'b0);
        push(T_RE,   0,     4'd0, 1'b0);
        send_str("\"ab\"c\n");
        drain();
        chk("err_quote", {31'd0, err_quote}, 32'd0);
        push(T_CHAR, 8'h22, 4'd0, 1'b0);
        push(T_CHAR, "p",   4'd0, 1'b0);
        push(T_FE,   0,     4'd0, 1'b0);
        push(T_CHAR, "q",   4'd1, 1'b0);
        push(T_CHAR, 8'h22, 4'd1, 1'b0);
        push(T_CHAR, 8'h22, 4'd1, 1'b0);
        push(T_CHAR, "r",   4'd1, 1'b0);
        push(T_CHAR, 8'h22, 4'd1, 1'b0);
        push(T_RE,   0,     4'd1, 1'b0);
        send_str("\"p,q\"\"r\"\n");
        drain();
`endif

        // Empty line
        push(T_RE, 0, 4'd0, 1'b0);
        send(8'h0A);
        drain();

        // Back-pressure: hold the first token for 5 cycles
        push(T_CHAR, "a", 4'd0, 1'b0);
        push(T_CHAR, "b", 4'd0, 1'b0);
        push(T_RE,   0,   4'd0, 1'b0);
        out_ready = 1'b0;
        send("a");
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_in_ready",  {31'd0, in_ready},  32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data",      {24'd0, out_data},  {24'd0, 8'h61});
            chk("stall_col",       {28'd0, out_col},   32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send("b");
        send(8'h0A);
        drain();

        // Reset mid-row with a pending token
        out_ready = 1'b0;
        send("z");
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid",  {31'd0, out_valid},  32'd0);
        chk("midrst_out_data",   {24'd0, out_data},   32'd0);
        chk("midrst_out_header", {31'd0, out_header}, 32'd1);
        chk("midrst_err_cols",   {31'd0, err_cols},   32'd0);
        chk("midrst_in_ready",   {31'd0, in_ready},   32'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("postrst_out_valid", {31'd0, out_valid}, 32'd0);
        push(T_RE, 0, 4'd0, 1'b1);
        send(8'h0A);
        drain();

        // Column overflow: 17 delimiters on one row
        for (int i = 0; i < 15; i++) begin
            push(T_FE, 0, 4'(i), 1'b0);
            send(8'h2C);
        end
        drain();
        chk("ovf_not_yet", {31'd0, err_ovf}, 32'd0);
        push(T_FE, 0, 4'd15, 1'b0);
        push(T_FE, 0, 4'd15, 1'b0);
        push(T_RE, 0, 4'd15, 1'b0);
        send(8'h2C);
        send(8'h2C);
        send(8'h0A);
        drain();
        chk("ovf_set", {31'd0, err_ovf}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
